spad_window_ctrl: RTL and testbench

SPAD_WINDOW_CTRL -- requirements
Module: spad_window_ctrl

---
 rtl/spad_pkg.sv | 16 +
 rtl/spad_window_ctrl.sv | 136 +++++++++++++
 tb/tb_spad_window_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spad_pkg.sv
// Shared definitions for the scratchpad window controller: FSM state encoding
// and default widths.
package spad_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam int DATA_BITWIDTH_DEF  = 16;
   localparam int ADDR_BITWIDTH_DEF  = 4;
   localparam int CFG_BITWIDTH_DEF   = 8;
   localparam int STALL_BITWIDTH     = 16;

endpackage

// File: rtl/spad_window_ctrl.sv
// Sliding-window reader over a circular scratchpad: pushes fill the RAM, RUN emits
// K taps per window for W windows. Optional stall counter: SPAD_WINDOW_STALL_CNT_EN.
module spad_window_ctrl
   import spad_pkg::*;
#(
   parameter int DATA_BITWIDTH = DATA_BITWIDTH_DEF,
   parameter int ADDR_BITWIDTH = ADDR_BITWIDTH_DEF,
   parameter int CFG_BITWIDTH  = CFG_BITWIDTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_start,
   input  logic [CFG_BITWIDTH-1:0]  cfg_kernel,
   input  logic [CFG_BITWIDTH-1:0]  cfg_stride,
   input  logic [CFG_BITWIDTH-1:0]  cfg_num_win,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_BITWIDTH-1:0] in_data,
   output logic                     ram_we0,
   output logic [ADDR_BITWIDTH-1:0] ram_addr0,
   output logic [DATA_BITWIDTH-1:0] ram_d0,
   output logic [ADDR_BITWIDTH-1:0] ram_addr1,
   input  logic [DATA_BITWIDTH-1:0] ram_q1,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_BITWIDTH-1:0] out_data,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
`ifdef SPAD_WINDOW_STALL_CNT_EN
   ,
   output logic [STALL_BITWIDTH-1:0] stall_cycles
`endif
);

   localparam int DEPTH = 2 ** ADDR_BITWIDTH;
   localparam int CNT_W = ADDR_BITWIDTH + 1;

   state_t                    state_q, state_d;
   logic [ADDR_BITWIDTH-1:0]  wr_ptr, rd_base;
   logic [CNT_W-1:0]          count, count_next, pop_amt;
   logic [CFG_BITWIDTH-1:0]   tap, win;
   logic [CFG_BITWIDTH-1:0]   k_q, s_q, w_q;

   logic in_run, push, fire, last_tap, final_win, win_end, start_acc;

   assign in_run    = (state_q == RUN);
   assign start_acc = (state_q == IDLE) && cfg_start;

   // Write side is decoupled from the FSM so data can be prefetched while idle.
   assign in_ready  = (count < CNT_W'(DEPTH));
   assign push      = in_valid && in_ready;
   assign ram_we0   = push;
   assign ram_addr0 = wr_ptr;
   assign ram_d0    = in_data;

   // A tap is only valid once its slot is filled, so it never aliases wr_ptr.
   assign ram_addr1 = in_run ? (rd_base + ADDR_BITWIDTH'(tap)) : rd_base;
   assign out_data  = ram_q1;
   assign out_valid = in_run && (32'(count) > 32'(tap));
   assign last_tap  = (tap == (k_q - CFG_BITWIDTH'(1)));
   assign out_last  = out_valid && last_tap;
   assign fire      = out_valid && out_ready;

   assign final_win = (win == (w_q - CFG_BITWIDTH'(1)));
   assign win_end   = fire && last_tap;

   // The final window also drops its overlap, leaving nothing stale behind.
   always_comb begin
      pop_amt = '0;
      if (win_end) pop_amt = final_win ? CNT_W'(k_q) : CNT_W'(s_q);
   end

   assign count_next = count + CNT_W'(push) - pop_amt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cfg_start) state_d = RUN;
         RUN:     if (win_end && final_win) state_d = FLUSH;
         FLUSH:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_base <= '0;
         count   <= '0;
         tap     <= '0;
         win     <= '0;
         k_q     <= '0;
         s_q     <= '0;
         w_q     <= '0;
      end else begin
         wr_ptr  <= wr_ptr + ADDR_BITWIDTH'(push);
         rd_base <= rd_base + ADDR_BITWIDTH'(pop_amt);
         count   <= count_next;
         if (start_acc) begin
            k_q <= cfg_kernel;
            s_q <= cfg_stride;
            w_q <= cfg_num_win;
            tap <= '0;
            win <= '0;
         end else if (fire) begin
            if (last_tap) begin
               tap <= '0;
               win <= win + CFG_BITWIDTH'(1);
            end else begin
               tap <= tap + CFG_BITWIDTH'(1);
            end
         end
      end
   end

`ifdef SPAD_WINDOW_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (start_acc)
         stall_cycles <= '0;
      else if (in_run && !out_valid && (stall_cycles != '1))
         stall_cycles <= stall_cycles + STALL_BITWIDTH'(1);
   end
`endif

endmodule

// File: tb/tb_spad_window_ctrl.sv
// Randomized bench for spad_window_ctrl against a queue-based window model,
// with a behavioural dual-port RAM standing in for the parent PE's scratchpad.
module tb_spad_window_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int CW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start;
   logic [CW-1:0] cfg_kernel, cfg_stride, cfg_num_win;
   logic          in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          ram_we0;
   logic [AW-1:0] ram_addr0, ram_addr1;
   logic [DW-1:0] ram_d0, ram_q1;
   logic          out_valid, out_ready, out_last, busy, done;
   logic [DW-1:0] out_data;
`ifdef SPAD_WINDOW_STALL_CNT_EN
   logic [15:0]   stall_cycles;
`endif

   always #5 clk = ~clk;

   spad_window_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .CFG_BITWIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_kernel(cfg_kernel), .cfg_stride(cfg_stride),
      .cfg_num_win(cfg_num_win),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ram_we0(ram_we0), .ram_addr0(ram_addr0), .ram_d0(ram_d0),
      .ram_addr1(ram_addr1), .ram_q1(ram_q1),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
`ifdef SPAD_WINDOW_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) if (ram_we0) mem[ram_addr0] <= ram_d0;
   assign ram_q1 = mem[ram_addr1];

   // Reference model: buffer contents as a queue, window position as plain ints.
   int q[$];
   int seen[$];
   bit m_run, m_flush;
   int m_k, m_s, m_w, m_tap, m_win, m_stall;
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   task automatic model_clear();
      q.delete();
      m_run = 0; m_flush = 0; m_tap = 0; m_win = 0; m_stall = 0;
   endtask

   task automatic cycle();
      bit ev, ir, push, fire;
      int pd, amt;
      @(negedge clk);
      ir = (q.size() < DEPTH);
      ev = m_run && (q.size() > m_tap);
      chk("in_ready", 32'(in_ready), 32'(ir));
      chk("out_valid", 32'(out_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(m_run || m_flush));
      chk("done", 32'(done), 32'(m_flush));
      chk("count", 32'(dut.count), q.size());
      chk("ram_we0", 32'(ram_we0), 32'(in_valid && ir));
      if (ev) begin
         chk("out_data", 32'(out_data), q[m_tap]);
         chk("out_last", 32'(out_last), 32'(m_tap == m_k - 1));
      end else begin
         chk("out_last_idle", 32'(out_last), 0);
      end
`ifdef SPAD_WINDOW_STALL_CNT_EN
      chk("stall_cycles", 32'(stall_cycles), m_stall);
`endif
      push = in_valid && ir;
      fire = ev && out_ready;
      pd   = 32'(in_data);
      if (fire) seen.push_back(32'(out_data));
      @(posedge clk);
      if (m_flush) begin
         m_flush = 0;
      end else if (m_run) begin
         if (!ev && m_stall < 65535) m_stall++;
         if (fire) begin
            if (m_tap == m_k - 1) begin
               amt = (m_win == m_w - 1) ? m_k : m_s;
               for (int i = 0; i < amt; i++) q.delete(0);
               m_tap = 0;
               if (m_win == m_w - 1) begin
                  m_run = 0;
                  m_flush = 1;
               end
               m_win++;
            end else begin
               m_tap++;
            end
         end
      end else if (cfg_start) begin
         m_k = 32'(cfg_kernel); m_s = 32'(cfg_stride); m_w = 32'(cfg_num_win);
         m_run = 1; m_tap = 0; m_win = 0; m_stall = 0;
      end
      if (push) q.push_back(pd);
      #1;
   endtask

   task automatic push_val(input int v);
      in_valid = 1'b1;
      in_data  = DW'(v);
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic start(input int k, input int s, input int w);
      cfg_kernel = CW'(k); cfg_stride = CW'(s); cfg_num_win = CW'(w);
      cfg_start = 1'b1;
      cycle();
      cfg_start = 1'b0;
   endtask

   task automatic run_to_done(input bit rnd);
      int budget = 400;
      while ((m_run || m_flush) && budget > 0) begin
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         cycle();
         budget--;
      end
      chk("run_timeout", 32'(m_run || m_flush), 0);
      out_ready = 1'b1;
      cycle();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_we0", 32'(ram_we0), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_count", 32'(dut.count), 0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_seq[9];
      rst_n = 1'b0; cfg_start = 1'b0; cfg_kernel = '0; cfg_stride = '0; cfg_num_win = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      do_reset();

      // Basic flow
      for (int i = 1; i <= 5; i++) push_val(i);
      out_ready = 1'b1;
      seen.delete();
      start(3, 1, 3);
      run_to_done(1'b0);
      exp_seq = '{1, 2, 3, 2, 3, 4, 3, 4, 5};
      chk("basic_len", seen.size(), 9);
      for (int i = 0; i < 9 && i < seen.size(); i++) chk("basic_tap", seen[i], exp_seq[i]);
      chk("basic_count", 32'(dut.count), 0);

      // Full buffer, then one stride-2 window frees space
      for (int i = 0; i < 16; i++) push_val(int'($urandom_range(0, 65535)));
      chk("full_ready", 32'(in_ready), 0);
      start(4, 2, 2);
      for (int i = 0; i < 4; i++) cycle();
      chk("after_pop_ready", 32'(in_ready), 1);
      run_to_done(1'b0);
      start(2, 2, 5);
      run_to_done(1'b0);

      // Wrap-around across address 15 -> 0
      do_reset();
      for (int i = 0; i < 14; i++) push_val(int'($urandom_range(0, 65535)));
      start(2, 2, 7);
      run_to_done(1'b1);
      chk("wrap_empty", 32'(dut.count), 0);
      for (int i = 0; i < 10; i++) push_val(int'($urandom_range(0, 65535)));
      start(2, 2, 5);
      run_to_done(1'b1);

      // Simultaneous push and last-tap pop
      for (int i = 0; i < 3; i++) push_val(int'($urandom_range(0, 65535)));
      out_ready = 1'b0;
      start(1, 1, 3);
      out_ready = 1'b1;
      push_val(int'($urandom_range(0, 65535)));
      chk("simul_count", 32'(dut.count), 3);
      run_to_done(1'b0);

      // Backpressure then starvation
      push_val(int'($urandom_range(0, 65535)));
      push_val(int'($urandom_range(0, 65535)));
      out_ready = 1'b0;
      start(3, 1, 2);
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("hold_data", 32'(out_data), q[0]);
         chk("hold_addr", 32'(ram_addr1), 32'(dut.rd_base));
      end
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("starve_valid", 32'(out_valid), 0);
      end
      push_val(int'($urandom_range(0, 65535)));
      run_to_done(1'b0);

      // Reset mid-RUN after two taps
      for (int i = 1; i <= 5; i++) push_val(i * 3);
      start(3, 1, 3);
      cycle();
      cycle();
      do_reset();
      for (int i = 0; i < 4; i++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
